// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: preloads reg[i]=i after reset, then round-robins ALU/load writebacks.
// Optional: define RF_WB_X0_DISCARD_EN to drop accepted writes that target register 0.
module rf_wb_arbiter #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done,
  output logic              err_oob
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   REG_LIM  = (ADDR_W + 1)'(NUM_REGS);

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              ptr_q;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_rd_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              init_done_q;
  logic              err_oob_q;

  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              oob;
  logic              x0_drop;

  // ptr_q names the requester that wins a tie; ptr_q==0 favours req0.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | ~ptr_q);
    grant1     = req1_valid & (~req0_valid |  ptr_q);
    req0_ready = (state_q == S_RUN) & grant0;
    req1_ready = (state_q == S_RUN) & grant1;
    xfer       = req0_ready | req1_ready;
    sel_rd     = grant1 ? req1_rd   : req0_rd;
    sel_data   = grant1 ? req1_data : req0_data;
    oob        = ({1'b0, sel_rd} >= REG_LIM);
  end

`ifdef RF_WB_X0_DISCARD_EN
  assign x0_drop = (sel_rd == '0);
`else
  assign x0_drop = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_rd_q     <= '0;
      rf_wdata_q  <= '0;
      init_done_q <= 1'b0;
      err_oob_q   <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          rf_we_q    <= 1'b1;
          rf_rd_q    <= cnt_q;
          rf_wdata_q <= DATA_W'(cnt_q);
          cnt_q      <= cnt_q + 1'b1;
          err_oob_q  <= 1'b0;
          if (cnt_q == LAST_REG) begin
            state_q     <= S_RUN;
            init_done_q <= 1'b1;
          end
        end
        S_RUN: begin
          rf_we_q   <= xfer & ~oob & ~x0_drop;
          err_oob_q <= xfer & oob;
          // Address/data only follow real writes so the port holds its last value otherwise.
          if (xfer && !oob && !x0_drop) begin
            rf_rd_q    <= sel_rd;
            rf_wdata_q <= sel_data;
          end
          if (xfer) begin
            ptr_q <= grant0;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_rd     = rf_rd_q;
  assign rf_wdata  = rf_wdata_q;
  assign init_done = init_done_q;
  assign err_oob   = err_oob_q;

endmodule
